// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch slice: FSM state encoding,
// the default HALT opcode and the bit positions of the instruction fields.
// No ports; imported by fetch_sequencer.
package fetch_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DISCARD = 3'd2,
    ST_VALID   = 3'd3,
    ST_HALTED  = 3'd4
  } fetch_state_e;

  localparam logic [3:0] HALT_OP_DEFAULT = 4'hF;

  // Instruction field positions (32-bit instruction word).
  localparam int COND_MSB   = 31;
  localparam int COND_LSB   = 28;
  localparam int OPCODE_MSB = 27;
  localparam int OPCODE_LSB = 24;
  localparam int S_BIT      = 23;
  localparam int DEST_MSB   = 22;
  localparam int DEST_LSB   = 19;
  localparam int IMM_MSB    = 18;
  localparam int IMM_LSB    = 3;
  localparam int SRC2_MSB   = 18;
  localparam int SRC2_LSB   = 15;
  localparam int SRC1_MSB   = 14;
  localparam int SRC1_LSB   = 11;

  function automatic logic [3:0] get_opcode(input logic [31:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Memory-ack watchdog: counts cycles a request waits without an ack and
// flags expiry on the cycle the TIMEOUT-th waiting cycle is reached.
// Ports:
//   clk      in  rising-edge clock
//   reset    in  asynchronous active-low reset
//   clear    in  restart the count (new transaction entered)
//   count_en in  request outstanding and not acked this cycle
//   expire   out this waiting cycle is the TIMEOUT-th one
module fetch_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expire
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Expiry is combinational so the sequencer can drop the request on the
  // very edge that completes the TIMEOUT-th waiting cycle.
  assign expire = count_en && (count == CNT_W'(TIMEOUT - 1));

  // Wait counter; clear wins over counting.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en && !expire) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, requests words from instruction
// memory (req/ack) and hands them to the decoder (valid/ready). Handles
// branch redirect/squash, HALT opcode stop and memory ack timeout.
// Ports:
//   clk, reset (async, active-low)       clocking
//   start                                begin/resume in IDLE/HALTED
//   imem_req/imem_addr/imem_ack/imem_data instruction memory handshake
//   instr_valid/instr_ready/instr_out/pc_out decoder handshake
//   branch_taken/branch_target           redirect pulse
//   halted, fetch_err                    status (fetch_err sticky)
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int               ADDR_W   = 8,
  parameter int               DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]       HALT_OP  = HALT_OP_DEFAULT,
  parameter int               TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic              halted,
  output logic              fetch_err
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              req_d, valid_d, halted_d, err_d;
  logic [ADDR_W-1:0] addr_d, pcout_d;
  logic [DATA_W-1:0] instr_d;
  logic              wd_clear, wd_expire;

  fetch_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (imem_req && !imem_ack),
    .expire   (wd_expire)
  );

  // Next-state and next-output logic. Branch is tested first in every
  // state because it outranks ready, ack, timeout and start. In FETCH,
  // imem_req=0 marks the one-cycle gap before (re)issuing at pc.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_d    = imem_req;
    addr_d   = imem_addr;
    valid_d  = instr_valid;
    instr_d  = instr_out;
    pcout_d  = pc_out;
    halted_d = halted;
    err_d    = fetch_err;
    wd_clear = 1'b0;

    case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end else if (start) begin
          state_d  = ST_FETCH;
          req_d    = 1'b1;
          addr_d   = pc_q;
          halted_d = 1'b0;
          wd_clear = 1'b1;
        end
      end

      ST_FETCH: begin
        if (!imem_req) begin
          if (branch_taken) begin
            pc_d = branch_target;
          end else begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
        end else if (branch_taken) begin
          pc_d     = branch_target;
          wd_clear = 1'b1;
          // Request cannot be withdrawn; wait for its ack in DISCARD.
          if (imem_ack) begin
            req_d = 1'b0;
          end else begin
            state_d = ST_DISCARD;
          end
        end else if (imem_ack) begin
          instr_d = imem_data;
          pcout_d = imem_addr;
          pc_d    = pc_q + 1'b1;
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = ST_VALID;
        end else if (wd_expire) begin
          req_d    = 1'b0;
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_HALTED;
        end
      end

      ST_DISCARD: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end
        if (imem_ack) begin
          req_d    = 1'b0;
          state_d  = ST_FETCH;
          wd_clear = 1'b1;
        end else if (wd_expire) begin
          req_d    = 1'b0;
          err_d    = 1'b1;
          halted_d = 1'b1;
          state_d  = ST_HALTED;
        end
      end

      ST_VALID: begin
        if (branch_taken) begin
          valid_d  = 1'b0;
          pc_d     = branch_target;
          req_d    = 1'b1;
          addr_d   = branch_target;
          state_d  = ST_FETCH;
          wd_clear = 1'b1;
        end else if (instr_ready) begin
          valid_d = 1'b0;
          if (get_opcode(instr_out) == HALT_OP) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            state_d  = ST_FETCH;
            req_d    = 1'b1;
            addr_d   = pc_q;
            wd_clear = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State, PC and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      imem_req    <= 1'b0;
      imem_addr   <= RESET_PC;
      instr_valid <= 1'b0;
      instr_out   <= '0;
      pc_out      <= '0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      instr_valid <= valid_d;
      instr_out   <= instr_d;
      pc_out      <= pcout_d;
      halted      <= halted_d;
      fetch_err   <= err_d;
    end
  end

endmodule
